// File: rtl/dcache_data_write_unit.sv
// Data-array write sink: buffers merged write requests in a small FIFO and drains them
// into the shared single-port SRAM, yielding to reads with a bounded starvation window.
module dcache_data_write_unit #(
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_in_ready,
    input  logic        io_in_valid,
    input  logic [31:0] io_in_bits_data,
    input  logic [5:0]  io_in_bits_set,
    input  logic [1:0]  io_in_bits_blockSelOH,
    input  logic [3:0]  io_in_bits_way,
    input  logic [3:0]  io_in_bits_mask,
    input  logic        io_rd_valid,
    input  logic [5:0]  io_rd_set,
    input  logic [1:0]  io_rd_blockSelOH,
    output logic        io_rd_ready,
    output logic        io_rd_conflict,
    output logic        io_sram_wen,
    output logic [6:0]  io_sram_addr,
    output logic [3:0]  io_sram_way,
    output logic [31:0] io_sram_wdata,
    output logic [3:0]  io_sram_wmask,
    output logic        io_empty,
    output logic        io_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STALL + 1);

    logic [31:0] data_mem [DEPTH];
    logic [5:0]  set_mem  [DEPTH];
    logic [1:0]  blk_mem  [DEPTH];
    logic [3:0]  way_mem  [DEPTH];
    logic [3:0]  mask_mem [DEPTH];

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic             err_q, err_d;

    logic        head_valid, force_wr, enq, write_fire;
    logic        head_oh, head_way_ok, head_mask_ok;
    logic [31:0] head_data;
    logic [5:0]  head_set;
    logic [1:0]  head_blk;
    logic [3:0]  head_way, head_mask;
    logic [DEPTH-1:0] hit;

    assign head_data = data_mem[rd_ptr_q];
    assign head_set  = set_mem[rd_ptr_q];
    assign head_blk  = blk_mem[rd_ptr_q];
    assign head_way  = way_mem[rd_ptr_q];
    assign head_mask = mask_mem[rd_ptr_q];

    assign head_valid   = (count_q != '0);
    assign force_wr     = (stall_q == SW'(MAX_STALL));
    assign io_in_ready  = (count_q != CW'(DEPTH));
    assign enq          = io_in_valid & io_in_ready;
    assign write_fire   = head_valid & (~io_rd_valid | force_wr);
    assign head_oh      = (head_blk == 2'b01) | (head_blk == 2'b10);
    assign head_way_ok  = |head_way;
    assign head_mask_ok = |head_mask;

    // Write strobe is suppressed in the reset cycle so discarded entries never reach the array.
    assign io_sram_wen   = reset & write_fire & head_oh & head_way_ok & head_mask_ok;
    assign io_sram_addr  = head_valid ? {head_set, head_blk[1]} : '0;
    assign io_sram_way   = head_valid ? head_way  : '0;
    assign io_sram_wdata = head_valid ? head_data : '0;
    assign io_sram_wmask = head_valid ? head_mask : '0;
    assign io_empty      = ~head_valid;
    assign io_err        = err_q;
    assign io_rd_ready   = ~force_wr;

    // The head still counts as a conflict even while it is being written this cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = vld_q[gi] & (set_mem[gi] == io_rd_set)
                       & (|(blk_mem[gi] & io_rd_blockSelOH));
    end
    assign io_rd_conflict = io_rd_valid & (|hit);

    always_comb begin
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        err_d    = write_fire & (~head_oh | ~head_way_ok);
        if (write_fire) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (enq) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        case ({enq, write_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (write_fire | ~head_valid) begin
            stall_d = '0;
        end else if (io_rd_valid & ~force_wr) begin
            stall_d = stall_q + SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    // Payload storage carries no reset; entry validity lives in vld_q.
    always_ff @(posedge clock) begin
        if (enq) begin
            data_mem[wr_ptr_q] <= io_in_bits_data;
            set_mem[wr_ptr_q]  <= io_in_bits_set;
            blk_mem[wr_ptr_q]  <= io_in_bits_blockSelOH;
            way_mem[wr_ptr_q]  <= io_in_bits_way;
            mask_mem[wr_ptr_q] <= io_in_bits_mask;
        end
    end
endmodule

// File: tb/tb_dcache_data_write_unit.sv
// Bench for dcache_data_write_unit: queue-based reference model, scoreboard of expected
// SRAM writes / error pulses, and a negedge monitor comparing every output.
module tb_dcache_data_write_unit;
    localparam int DEPTH     = 4;
    localparam int MAX_STALL = 8;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  set;
        logic [1:0]  blk;
        logic [3:0]  way;
        logic [3:0]  mask;
    } req_t;

    typedef struct {
        bit          is_err;
        logic [6:0]  addr;
        logic [3:0]  way;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    req_t        cur;
    logic        rd_valid = 1'b0;
    logic [5:0]  rd_set = '0;
    logic [1:0]  rd_blk = '0;

    logic        in_ready, rd_ready, rd_conflict, sram_wen, empty, err;
    logic [6:0]  sram_addr;
    logic [3:0]  sram_way, sram_wmask;
    logic [31:0] sram_wdata;

    int checks = 0;
    int errors = 0;

    req_t mq[$];
    exp_t sb[$];
    int   stall_m = 0;
    bit   err_m = 0;
    bit   started = 0;

    dcache_data_write_unit #(.DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
        .clock(clk), .reset(rst_n),
        .io_in_ready(in_ready), .io_in_valid(in_valid),
        .io_in_bits_data(cur.data), .io_in_bits_set(cur.set),
        .io_in_bits_blockSelOH(cur.blk), .io_in_bits_way(cur.way),
        .io_in_bits_mask(cur.mask),
        .io_rd_valid(rd_valid), .io_rd_set(rd_set), .io_rd_blockSelOH(rd_blk),
        .io_rd_ready(rd_ready), .io_rd_conflict(rd_conflict),
        .io_sram_wen(sram_wen), .io_sram_addr(sram_addr), .io_sram_way(sram_way),
        .io_sram_wdata(sram_wdata), .io_sram_wmask(sram_wmask),
        .io_empty(empty), .io_err(err)
    );

    always #5 clk = ~clk;

    function automatic bit is_oh(input logic [1:0] b);
        return (b == 2'b01) || (b == 2'b10);
    endfunction

    function automatic bit is_legal(input req_t r);
        return is_oh(r.blk) && (r.way != 0) && (r.mask != 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of pending requests, reads win unless a write has starved MAX_STALL cycles.
    always @(posedge clk) begin : model
        int   n;
        bit   fire;
        req_t h;
        exp_t e;
        started = 1;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            stall_m = 0;
            err_m   = 0;
        end else begin
            n     = mq.size();
            fire  = (n > 0) && (!rd_valid || stall_m == MAX_STALL);
            err_m = 0;
            if (fire) begin
                h     = mq.pop_front();
                err_m = !is_oh(h.blk) || (h.way == 0);
            end
            if (fire || n == 0) stall_m = 0;
            else if (rd_valid && stall_m < MAX_STALL) stall_m++;
            if (in_valid && n != DEPTH) begin
                mq.push_back(cur);
                e.is_err = !is_oh(cur.blk) || (cur.way == 0);
                e.addr   = {cur.set, cur.blk[1]};
                e.way    = cur.way;
                e.data   = cur.data;
                e.mask   = cur.mask;
                if (e.is_err || cur.mask != 0) sb.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : monitor
        bit   conf, pwen;
        exp_t e;
        if (started) begin
            conf = 0;
            foreach (mq[i])
                if (mq[i].set == rd_set && (mq[i].blk & rd_blk) != 0) conf = 1;
            conf = conf && rd_valid;
            pwen = rst_n && mq.size() > 0 && (!rd_valid || stall_m == MAX_STALL)
                   && is_legal(mq[0]);
            chk("in_ready", in_ready, mq.size() != DEPTH);
            chk("rd_ready", rd_ready, stall_m != MAX_STALL);
            chk("empty", empty, mq.size() == 0);
            chk("conflict", rd_conflict, conf);
            chk("wen", sram_wen, pwen);
            chk("err", err, err_m);
            if (err === 1'b1) begin
                if (sb.size() == 0) chk("err_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    $display("ERR pulse exp_is_err=%0d", e.is_err);
                    chk("err_kind", 1, e.is_err);
                end
            end
            if (sram_wen === 1'b1) begin
                if (sb.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    $display("WR addr=%02h way=%b data=%08h mask=%h", sram_addr, sram_way,
                             sram_wdata, sram_wmask);
                    chk("wr_kind", 0, e.is_err);
                    chk("wr_addr", sram_addr, e.addr);
                    chk("wr_way", sram_way, e.way);
                    chk("wr_data", sram_wdata, e.data);
                    chk("wr_mask", sram_wmask, e.mask);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [5:0] s, input logic [1:0] b,
                        input logic [3:0] w, input logic [3:0] m);
        bit acc;
        int k;
        cur.data = d; cur.set = s; cur.blk = b; cur.way = w; cur.mask = m;
        in_valid = 1'b1;
        acc = 0;
        for (k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   p;
        r.data = $urandom;
        r.set  = 6'($urandom_range(0, 3));
        p      = $urandom_range(0, 9);
        r.blk  = (p < 4) ? 2'b01 : (p < 8) ? 2'b10 : (p == 8) ? 2'b11 : 2'b00;
        r.way  = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
        r.mask = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        return r;
    endfunction

    initial begin
        req_t r;
        cur = '{default: '0};
        step(2);
        rst_n = 1'b1;
        step(1);

        // basic write, then idle
        push(32'hDEADBEEF, 6'd5, 2'b10, 4'b0100, 4'hF);
        step(3);

        // fill under read pressure; fifth request waits for first dequeue
        rd_valid = 1'b1; rd_set = 6'd40; rd_blk = 2'b01;
        for (int i = 0; i < 5; i++) push(32'h1000 + i, 6'(10 + i), 2'b01, 4'b0001, 4'hF);
        rd_valid = 1'b0;
        step(8);

        // single buffered write starved by continuous reads
        rd_valid = 1'b1;
        push(32'hCAFE0003, 6'd7, 2'b01, 4'b1000, 4'h3);
        step(12);
        rd_valid = 1'b0;
        step(2);

        // read/write overlap detection
        rd_valid = 1'b1; rd_set = 6'd3; rd_blk = 2'b01;
        push(32'h33333333, 6'd3, 2'b01, 4'b0010, 4'hF);
        step(2);
        rd_blk = 2'b10;
        step(2);
        rd_valid = 1'b0;
        step(3);

        // illegal requests and a legal no-op
        push(32'h11111111, 6'd1, 2'b11, 4'b0001, 4'hF);
        push(32'h22222222, 6'd2, 2'b01, 4'b0000, 4'hF);
        push(32'h44444444, 6'd4, 2'b10, 4'b0001, 4'h0);
        step(4);

        // reset discards buffered writes
        rd_valid = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h5000 + i, 6'(20 + i), 2'b10, 4'b0100, 4'hF);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        rd_valid = 1'b0;
        step(5);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            r        = rand_req();
            cur      = r;
            in_valid = ($urandom_range(0, 1) == 1);
            rd_valid = ($urandom_range(0, 9) < 6);
            rd_set   = 6'($urandom_range(0, 3));
            rd_blk   = 2'($urandom_range(0, 3));
            rst_n    = ($urandom_range(0, 99) != 0);
            step(1);
        end
        rst_n = 1'b1; in_valid = 1'b0; rd_valid = 1'b0;
        step(15);

        chk("drain_sb", sb.size(), 0);
        chk("drain_empty", empty, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
